// File: rtl/wb_stage_gen.sv
// Write-back stage: aligns and extends load data, merges two-beat word-crossing
// loads, and keeps a short tagged history of retired results for forwarding.
module wb_stage_gen #(
    parameter int XLEN        = 32,
    parameter int FWD_DEPTH   = 2,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_ld_wb,
    input  logic [2:0]              ld_code_wb,
    input  logic [XLEN-1:0]         rd_data_wb,
    input  logic [XLEN-1:0]         ld_data_wb,
    input  logic                    ld_valid_wb,
    input  logic                    wbk_en_wb,
    input  logic [4:0]              wbk_rd_wb,
    input  logic                    stall,
    input  logic                    rst_pipe,
    output logic [XLEN-1:0]         wbk_data_wb,
    output logic                    wbk_we_wb,
    output logic [4:0]              wbk_rd_out,
    output logic                    stall_req,
    output logic                    ma_req,
    output logic [XLEN-1:0]         ma_adr,
    output logic                    misalign_exc,
    output logic [FWD_DEPTH*XLEN-1:0] fwd_data,
    output logic [FWD_DEPTH*5-1:0]  fwd_rd,
    output logic [FWD_DEPTH-1:0]    fwd_vld
);
    // state | meaning
    // IDLE  | single-beat operation; crossing loads capture beat 1 here
    // WAIT2 | holding beat 1 in lo_buf, waiting for the next word

    localparam int BYTES = XLEN / 8;
    localparam int OFSW  = $clog2(BYTES);

    typedef enum logic {IDLE = 1'b0, WAIT2 = 1'b1} state_t;

    state_t              state;
    logic [XLEN-1:0]     lo_buf;
    logic [XLEN-1:0]     hist_data [FWD_DEPTH];
    logic [4:0]          hist_rd   [FWD_DEPTH];

    logic [OFSW-1:0]     ofs;
    logic [3:0]          size;
    logic                sgn;
    logic [4:0]          span;
    logic                crossing;
    logic [2*XLEN-1:0]   window;
    logic [2*XLEN-1:0]   shifted;
    logic [6:0]          nbits;
    logic                msb;
    logic [XLEN-1:0]     ld_ext;
    logic                retire;
    logic                advance;

    assign ofs        = rd_data_wb[OFSW-1:0];
    assign wbk_rd_out = wbk_rd_wb;
    assign ma_adr     = (rd_data_wb & ~XLEN'(BYTES - 1)) + XLEN'(BYTES);

    // size 0 marks an unsupported code: data 0, never treated as crossing
    always_comb begin
        size = 4'd0;
        sgn  = 1'b0;
        case (ld_code_wb)
            3'b000: begin size = 4'd1; sgn = 1'b1; end
            3'b001: begin size = 4'd2; sgn = 1'b1; end
            3'b010: begin size = 4'd4; sgn = 1'b1; end
            3'b100: size = 4'd1;
            3'b101: size = 4'd2;
            3'b011: if (XLEN == 64) size = 4'd8;
            3'b110: if (XLEN == 64) size = 4'd4;
            default: size = 4'd0;
        endcase
    end

    assign span     = 5'(ofs) + 5'(size);
    assign crossing = cmd_ld_wb & (size != 4'd0) & (span > 5'(BYTES));

    always_comb begin
        window  = (state == WAIT2) ? {ld_data_wb, lo_buf} : {{XLEN{1'b0}}, ld_data_wb};
        shifted = window >> {ofs, 3'b000};
        nbits   = {size, 3'b000};
        case (size)
            4'd1:    msb = shifted[7];
            4'd2:    msb = shifted[15];
            4'd4:    msb = shifted[31];
            4'd8:    msb = shifted[63];
            default: msb = 1'b0;
        endcase
        ld_ext = '0;
        for (int i = 0; i < XLEN; i++)
            ld_ext[i] = (i < int'(nbits)) ? shifted[i] : (sgn & msb);
    end

    assign retire      = (state == WAIT2) ? ld_valid_wb : ~crossing;
    assign advance     = retire & ~stall & ~rst_pipe;
    assign wbk_data_wb = (cmd_ld_wb || state == WAIT2) ? ld_ext : rd_data_wb;
    assign wbk_we_wb   = wbk_en_wb & (wbk_rd_wb != 5'd0) & advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lo_buf       <= '0;
            stall_req    <= 1'b0;
            ma_req       <= 1'b0;
            misalign_exc <= 1'b0;
        end else if (rst_pipe) begin
            state        <= IDLE;
            lo_buf       <= '0;
            stall_req    <= 1'b0;
            ma_req       <= 1'b0;
            misalign_exc <= 1'b0;
        end else begin
            misalign_exc <= 1'b0;
            case (state)
                IDLE: begin
                    if (crossing && !stall) begin
                        if (MISALIGN_EN) begin
                            lo_buf    <= ld_data_wb;
                            state     <= WAIT2;
                            stall_req <= 1'b1;
                            ma_req    <= 1'b1;
                        end else begin
                            misalign_exc <= 1'b1;
                        end
                    end
                end
                WAIT2: begin
                    if (ld_valid_wb && !stall) begin
                        state     <= IDLE;
                        stall_req <= 1'b0;
                        ma_req    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // entry 0 is the newest retire; older entries ripple toward higher indices
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_vld <= '0;
            for (int i = 0; i < FWD_DEPTH; i++) begin
                hist_data[i] <= '0;
                hist_rd[i]   <= '0;
            end
        end else if (rst_pipe) begin
            fwd_vld <= '0;
            for (int i = 0; i < FWD_DEPTH; i++) begin
                hist_data[i] <= '0;
                hist_rd[i]   <= '0;
            end
        end else if (advance) begin
            hist_data[0] <= wbk_data_wb;
            hist_rd[0]   <= wbk_rd_wb;
            fwd_vld[0]   <= wbk_we_wb;
            for (int i = FWD_DEPTH - 1; i > 0; i--) begin
                hist_data[i] <= hist_data[i-1];
                hist_rd[i]   <= hist_rd[i-1];
                fwd_vld[i]   <= fwd_vld[i-1];
            end
        end
    end

    always_comb begin
        fwd_data = '0;
        fwd_rd   = '0;
        for (int i = 0; i < FWD_DEPTH; i++) begin
            fwd_data[i*XLEN +: XLEN] = hist_data[i];
            fwd_rd[i*5 +: 5]         = hist_rd[i];
        end
    end

endmodule

// File: tb/tb_wb_stage_gen.sv
// Directed bench for wb_stage_gen: three instances (32-bit/3-deep merging,
// 64-bit merging, 32-bit flagging) share one stimulus stream.
module tb_wb_stage_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_ld;
    logic [2:0]  ld_code;
    logic [63:0] rd_data;
    logic [63:0] ld_data;
    logic        ld_valid;
    logic        wbk_en;
    logic [4:0]  wbk_rd;
    logic        stall;
    logic        rst_pipe;

    logic [31:0] a_data, a_madr;
    logic        a_we, a_sreq, a_mreq, a_exc;
    logic [4:0]  a_rd;
    logic [95:0] a_fdata;
    logic [14:0] a_frd;
    logic [2:0]  a_fvld;

    logic [63:0]  b_data, b_madr;
    logic         b_we, b_sreq, b_mreq, b_exc;
    logic [4:0]   b_rd;
    logic [127:0] b_fdata;
    logic [9:0]   b_frd;
    logic [1:0]   b_fvld;

    logic [31:0] c_data, c_madr;
    logic        c_we, c_sreq, c_mreq, c_exc;
    logic [4:0]  c_rd;
    logic [63:0] c_fdata;
    logic [9:0]  c_frd;
    logic [1:0]  c_fvld;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_stage_gen #(.XLEN(32), .FWD_DEPTH(3), .MISALIGN_EN(1'b1)) u_a (
        .clk(clk), .rst(rst), .cmd_ld_wb(cmd_ld), .ld_code_wb(ld_code),
        .rd_data_wb(rd_data[31:0]), .ld_data_wb(ld_data[31:0]), .ld_valid_wb(ld_valid),
        .wbk_en_wb(wbk_en), .wbk_rd_wb(wbk_rd), .stall(stall), .rst_pipe(rst_pipe),
        .wbk_data_wb(a_data), .wbk_we_wb(a_we), .wbk_rd_out(a_rd), .stall_req(a_sreq),
        .ma_req(a_mreq), .ma_adr(a_madr), .misalign_exc(a_exc),
        .fwd_data(a_fdata), .fwd_rd(a_frd), .fwd_vld(a_fvld));

    wb_stage_gen #(.XLEN(64), .FWD_DEPTH(2), .MISALIGN_EN(1'b1)) u_b (
        .clk(clk), .rst(rst), .cmd_ld_wb(cmd_ld), .ld_code_wb(ld_code),
        .rd_data_wb(rd_data), .ld_data_wb(ld_data), .ld_valid_wb(ld_valid),
        .wbk_en_wb(wbk_en), .wbk_rd_wb(wbk_rd), .stall(stall), .rst_pipe(rst_pipe),
        .wbk_data_wb(b_data), .wbk_we_wb(b_we), .wbk_rd_out(b_rd), .stall_req(b_sreq),
        .ma_req(b_mreq), .ma_adr(b_madr), .misalign_exc(b_exc),
        .fwd_data(b_fdata), .fwd_rd(b_frd), .fwd_vld(b_fvld));

    wb_stage_gen #(.XLEN(32), .FWD_DEPTH(2), .MISALIGN_EN(1'b0)) u_c (
        .clk(clk), .rst(rst), .cmd_ld_wb(cmd_ld), .ld_code_wb(ld_code),
        .rd_data_wb(rd_data[31:0]), .ld_data_wb(ld_data[31:0]), .ld_valid_wb(ld_valid),
        .wbk_en_wb(wbk_en), .wbk_rd_wb(wbk_rd), .stall(stall), .rst_pipe(rst_pipe),
        .wbk_data_wb(c_data), .wbk_we_wb(c_we), .wbk_rd_out(c_rd), .stall_req(c_sreq),
        .ma_req(c_mreq), .ma_adr(c_madr), .misalign_exc(c_exc),
        .fwd_data(c_fdata), .fwd_rd(c_frd), .fwd_vld(c_fvld));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        cmd_ld = 1'b0; ld_valid = 1'b0; stall = 1'b0; wbk_en = 1'b0;
        rst_pipe = 1'b1;
        tick();
        rst_pipe = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_ld = 1'b0; ld_code = 3'd0; rd_data = '0; ld_data = '0;
        ld_valid = 1'b0; wbk_en = 1'b0; wbk_rd = 5'd0; stall = 1'b0; rst_pipe = 1'b0;
        #2;
        chk("rst_sreq", 128'(a_sreq), 128'(0));
        chk("rst_mreq", 128'(a_mreq), 128'(0));
        chk("rst_exc",  128'(c_exc),  128'(0));
        chk("rst_fvld", 128'(a_fvld), 128'(0));
        chk("rst_fdata", 128'(a_fdata), 128'(0));
        chk("rst_frd",  128'(a_frd),  128'(0));
        tick();
        rst = 1'b0;
        tick();

        // LB / LBU at byte 3
        cmd_ld = 1'b1; ld_code = 3'b000; rd_data = 64'h1003; ld_data = 64'h80FF_1234;
        wbk_en = 1'b1; wbk_rd = 5'd5;
        #1;
        chk("lb_data", 128'(a_data), 128'(32'hFFFF_FF80));
        chk("lb_we",   128'(a_we),   128'(1));
        chk("lb_rdout", 128'(a_rd),  128'(5));
        ld_code = 3'b100;
        #1;
        chk("lbu_data", 128'(a_data), 128'(32'h0000_0080));
        tick();
        chk("lbu_fwd_data", 128'(a_fdata[31:0]), 128'(32'h80));
        chk("lbu_fwd_rd",   128'(a_frd[4:0]),    128'(5));
        chk("lbu_fwd_vld",  128'(a_fvld),        128'(3'b001));

        // misaligned LW, second beat after two idle cycles
        flush();
        chk("flush_fvld", 128'(a_fvld), 128'(0));
        cmd_ld = 1'b1; ld_code = 3'b010; rd_data = 64'h1002; ld_data = 64'hDDCC_BBAA;
        wbk_en = 1'b1; wbk_rd = 5'd7; ld_valid = 1'b0;
        #1;
        chk("mis_n_we",   128'(a_we),   128'(0));
        chk("mis_n_sreq", 128'(a_sreq), 128'(0));
        tick();
        ld_data = '0;
        #1;
        chk("mis_n1_sreq", 128'(a_sreq), 128'(1));
        chk("mis_n1_mreq", 128'(a_mreq), 128'(1));
        chk("mis_n1_madr", 128'(a_madr), 128'(32'h1004));
        chk("mis_n1_we",   128'(a_we),   128'(0));
        tick();
        chk("mis_n2_sreq", 128'(a_sreq), 128'(1));
        chk("mis_n2_we",   128'(a_we),   128'(0));
        chk("mis_n2_fvld", 128'(a_fvld), 128'(0));
        tick();
        ld_data = 64'h4433_2211; ld_valid = 1'b1;
        #1;
        chk("mis_n3_sreq", 128'(a_sreq), 128'(1));
        chk("mis_n3_we",   128'(a_we),   128'(1));
        chk("mis_n3_data", 128'(a_data), 128'(32'h2211_DDCC));
        tick();
        cmd_ld = 1'b0; ld_valid = 1'b0; rd_data = 64'h77;
        #1;
        chk("mis_n4_sreq", 128'(a_sreq), 128'(0));
        chk("mis_n4_mreq", 128'(a_mreq), 128'(0));
        chk("mis_n4_data", 128'(a_data), 128'(32'h77));
        chk("mis_n4_fdata", 128'(a_fdata[31:0]), 128'(32'h2211_DDCC));
        chk("mis_n4_frd",   128'(a_frd[4:0]),    128'(7));
        chk("mis_n4_fvld",  128'(a_fvld),        128'(3'b001));

        // 64-bit LWU / LW / LD; unsupported codes on the 32-bit instance
        flush();
        cmd_ld = 1'b1; ld_code = 3'b110; rd_data = 64'h2004;
        ld_data = 64'h8765_4321_DEAD_BEEF; wbk_en = 1'b1; wbk_rd = 5'd3;
        #1;
        chk("lwu64_data", 128'(b_data), 128'(64'h0000_0000_8765_4321));
        chk("lwu64_we",   128'(b_we),   128'(1));
        chk("lwu32_data", 128'(a_data), 128'(32'h0));
        chk("lwu32_we",   128'(a_we),   128'(1));
        ld_code = 3'b010;
        #1;
        chk("lw64_data", 128'(b_data), 128'(64'hFFFF_FFFF_8765_4321));
        ld_code = 3'b011; rd_data = 64'h2000; ld_data = 64'h1122_3344_5566_7788;
        #1;
        chk("ld64_data", 128'(b_data), 128'(64'h1122_3344_5566_7788));
        chk("ld32_data", 128'(a_data), 128'(32'h0));
        chk("ld64_madr", 128'(b_madr), 128'(64'h2008));

        // history ordering, stall hold, rd 0
        flush();
        cmd_ld = 1'b0; wbk_en = 1'b1;
        wbk_rd = 5'd1; rd_data = 64'hA; tick();
        wbk_rd = 5'd2; rd_data = 64'hB; tick();
        wbk_rd = 5'd3; rd_data = 64'hC; tick();
        chk("hist_frd",   128'(a_frd),   128'(15'b00001_00010_00011));
        chk("hist_fdata", 128'(a_fdata), 128'({32'hA, 32'hB, 32'hC}));
        chk("hist_fvld",  128'(a_fvld),  128'(3'b111));
        stall = 1'b1; wbk_rd = 5'd4; rd_data = 64'hE;
        #1;
        chk("stall_we", 128'(a_we), 128'(0));
        tick(); tick();
        chk("stall_frd",   128'(a_frd),   128'(15'b00001_00010_00011));
        chk("stall_fdata", 128'(a_fdata), 128'({32'hA, 32'hB, 32'hC}));
        stall = 1'b0; wbk_rd = 5'd0; rd_data = 64'hD;
        #1;
        chk("rd0_we", 128'(a_we), 128'(0));
        tick();
        chk("rd0_fvld",  128'(a_fvld),  128'(3'b110));
        chk("rd0_frd",   128'(a_frd),   128'(15'b00010_00011_00000));
        chk("rd0_fdata", 128'(a_fdata[31:0]), 128'(32'hD));

        // stall with beat present in WAIT2, then rst_pipe
        cmd_ld = 1'b1; ld_code = 3'b010; rd_data = 64'h1002; ld_data = 64'hDDCC_BBAA;
        wbk_en = 1'b1; wbk_rd = 5'd7;
        #1;
        chk("w2_entry_we", 128'(a_we), 128'(0));
        tick();
        chk("w2_sreq", 128'(a_sreq), 128'(1));
        stall = 1'b1; ld_valid = 1'b1;
        #1;
        chk("w2_stall_we", 128'(a_we), 128'(0));
        tick();
        chk("w2_stall_sreq", 128'(a_sreq), 128'(1));
        chk("w2_stall_fvld", 128'(a_fvld), 128'(3'b110));
        stall = 1'b0; rst_pipe = 1'b1;
        #1;
        chk("rp_we", 128'(a_we), 128'(0));
        tick();
        rst_pipe = 1'b0; cmd_ld = 1'b0; ld_valid = 1'b0;
        #1;
        chk("rp_sreq", 128'(a_sreq), 128'(0));
        chk("rp_mreq", 128'(a_mreq), 128'(0));
        chk("rp_fvld", 128'(a_fvld), 128'(0));

        // async rst mid-WAIT2
        wbk_rd = 5'd9; rd_data = 64'h99;
        tick();
        chk("pre_rst_fvld", 128'(a_fvld), 128'(3'b001));
        cmd_ld = 1'b1; ld_code = 3'b010; rd_data = 64'h1002;
        tick();
        chk("pre_rst_sreq", 128'(a_sreq), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sreq",  128'(a_sreq),  128'(0));
        chk("arst_fvld",  128'(a_fvld),  128'(0));
        chk("arst_fdata", 128'(a_fdata), 128'(0));
        rst = 1'b0; cmd_ld = 1'b0;
        tick();

        // crossing LH with merging disabled
        flush();
        wbk_en = 1'b1; wbk_rd = 5'd8; rd_data = 64'h55;
        tick();
        chk("nm_pre_fvld", 128'(c_fvld), 128'(2'b01));
        cmd_ld = 1'b1; ld_code = 3'b001; rd_data = 64'h3003; ld_data = 64'h1234_5678;
        wbk_rd = 5'd6;
        #1;
        chk("nm_we",  128'(c_we),  128'(0));
        chk("nm_exc0", 128'(c_exc), 128'(0));
        tick();
        cmd_ld = 1'b0; wbk_en = 1'b0;
        #1;
        chk("nm_exc1",  128'(c_exc),  128'(1));
        chk("nm_sreq",  128'(c_sreq), 128'(0));
        chk("nm_fvld",  128'(c_fvld), 128'(2'b01));
        chk("nm_frd",   128'(c_frd),  128'(10'b00000_01000));
        chk("nm_fdata", 128'(c_fdata[31:0]), 128'(32'h55));
        tick();
        chk("nm_exc2", 128'(c_exc), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
